// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU command sequencer.
//   - ALU opcode constants (command encoding seen by the gate-delay ALU)
//   - sequencer FSM state encoding
//   - bit positions inside the packed {overflow, carryout, zero} flag vector
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_SLT  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StResp   = 2'd2
    } seq_state_e;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF   = 2;

    // Carry and overflow only carry meaning for the adder paths.
    function automatic logic is_arith(input logic [2:0] cmd);
        return (cmd == OP_ADD) || (cmd == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_seq_settle_timer.sv
// alu_seq_settle_timer: loadable down-counter that marks the end of a settle window.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   load       - load load_value into the counter this edge
//   load_value - cycles remaining minus one
//   done       - high while the counter is 0
module alu_seq_settle_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             done
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator side of the 32-bit ALU command interface.
// Accepts a request, drives command/operands to the ALU, holds them for SETTLE_CYCLES clocks,
// then captures result and masked flags and offers them on the response channel.
// Ports:
//   clk, rst_n                       - clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready              - request handshake; req_cmd, req_a, req_b payload
//   alu_command/operandA/operandB    - held stable towards the ALU between acceptances
//   alu_result/carryout/zero/overflow- ALU outputs, sampled at the end of the settle window
//   rsp_valid/rsp_ready              - response handshake; rsp_result, rsp_flags {ovf,carry,zero}
//   busy                             - high whenever the FSM is not idle
// Build option: ALU_SEQ_BACK2BACK_EN lets a new request be accepted in the same edge that
// retires a response (req_ready then follows rsp_ready combinationally while responding).
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_cmd,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [2:0]       alu_command,
    output logic [WIDTH-1:0] alu_operandA,
    output logic [WIDTH-1:0] alu_operandB,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags,
    output logic             busy
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_op_sequencer: SETTLE_CYCLES must be within 1..15");
    end
    if ((SETTLE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("alu_op_sequencer: CNT_W too narrow for SETTLE_CYCLES-1");
    end

    localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);

    seq_state_e       state_d, state_q;
    logic [2:0]       cmd_d, cmd_q;
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic [WIDTH-1:0] res_d, res_q;
    logic [2:0]       flg_d, flg_q;
    logic             timer_load;
    logic             timer_done;
    logic             accept;

    alu_seq_settle_timer #(
        .CNT_W(CNT_W)
    ) u_settle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timer_load),
        .load_value(SettleLoad),
        .done      (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        flg_d      = flg_q;
        timer_load = 1'b0;
        req_ready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
            end
            StSettle: begin
                if (timer_done) begin
                    res_d             = alu_result;
                    flg_d[FLAG_ZERO]  = alu_zero;
                    flg_d[FLAG_CARRY] = alu_carryout & is_arith(cmd_q);
                    flg_d[FLAG_OVF]   = alu_overflow & is_arith(cmd_q);
                    state_d           = StResp;
                end
            end
            StResp: begin
`ifdef ALU_SEQ_BACK2BACK_EN
                req_ready = rsp_ready;
`endif
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Acceptance overrides the idle/retire transition so the back-to-back path
        // goes straight from responding to settling.
        accept = req_valid && req_ready;
        if (accept) begin
            cmd_d      = req_cmd;
            a_d        = req_a;
            b_d        = req_b;
            timer_load = 1'b1;
            state_d    = StSettle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cmd_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign alu_command  = cmd_q;
    assign alu_operandA = a_q;
    assign alu_operandB = b_q;
    assign rsp_result   = res_q;
    assign rsp_flags    = flg_q;
    assign rsp_valid    = (state_q == StResp);
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int S = 4;
`ifdef ALU_SEQ_BACK2BACK_EN
    localparam int SPACING = S + 1;
`else
    localparam int SPACING = S + 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_cmd = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [2:0]  alu_command;
    logic [31:0] alu_operandA, alu_operandB, alu_result;
    logic        alu_carryout, alu_zero, alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_times[$];

    alu_op_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_command (alu_command),
        .alu_operandA(alu_operandA),
        .alu_operandB(alu_operandB),
        .alu_result  (alu_result),
        .alu_carryout(alu_carryout),
        .alu_zero    (alu_zero),
        .alu_overflow(alu_overflow),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural ALU: {overflow, carryout, result}. Logic ops drive junk carry/overflow = 1.
    function automatic logic [33:0] alu_ref(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic co, ov;
        co = 1'b1;
        ov = 1'b1;
        s = 33'd0;
        case (c)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0];
                co = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = a ^ b;
            3'd4: r = ~(a & b);
            3'd5: r = a & b;
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {ov, co, r};
    endfunction

    always_comb begin
        {alu_overflow, alu_carryout, alu_result} = alu_ref(alu_command, alu_operandA,
                                                           alu_operandB);
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: an op in flight, its age in edges since acceptance, and the last
    // accepted operands / last captured response.
    logic        m_has = 1'b0;
    int          m_age = 0;
    logic [2:0]  m_cmd = 3'd0;
    logic [31:0] m_a = 32'd0, m_b = 32'd0, m_res = 32'd0;
    logic [2:0]  m_flg = 3'd0;
    logic        e_valid, e_ready, e_rsp_hs, e_req_hs, e_arith;
    logic [33:0] e_raw;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_has = 1'b0;
            m_age = 0;
            m_cmd = 3'd0;
            m_a = 32'd0;
            m_b = 32'd0;
            m_res = 32'd0;
            m_flg = 3'd0;
        end else begin
            e_valid = m_has && (m_age >= S);
`ifdef ALU_SEQ_BACK2BACK_EN
            e_ready = !m_has || (e_valid && rsp_ready);
`else
            e_ready = !m_has;
`endif
            check("req_ready", req_ready, e_ready);
            check("rsp_valid", rsp_valid, e_valid);
            check("busy", busy, m_has);
            check("alu_command", alu_command, m_cmd);
            check("alu_operandA", alu_operandA, m_a);
            check("alu_operandB", alu_operandB, m_b);
            check("rsp_result", rsp_result, m_res);
            check("rsp_flags", rsp_flags, m_flg);

            e_rsp_hs = e_valid && rsp_ready;
            e_req_hs = req_valid && e_ready;
            if (e_rsp_hs) hs_times.push_back(cyc);
            if (m_has && !e_valid) begin
                m_age++;
                if (m_age == S) begin
                    e_raw = alu_ref(m_cmd, m_a, m_b);
                    e_arith = (m_cmd == 3'd0) || (m_cmd == 3'd1);
                    m_res = e_raw[31:0];
                    m_flg = {e_raw[33] & e_arith, e_raw[32] & e_arith, e_raw[31:0] == 32'd0};
                end
            end
            if (e_rsp_hs) m_has = 1'b0;
            if (e_req_hs) begin
                m_has = 1'b1;
                m_age = 0;
                m_cmd = req_cmd;
                m_a = req_a;
                m_b = req_b;
            end
        end
    end

    // Present a request and hold it until accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(posedge clk);
        #1;
        req_cmd = c;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic retire();
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check("rst_req_ready", req_ready, 32'd1);
        check("rst_rsp_valid", rsp_valid, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_alu_command", alu_command, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        #20;
        rst_n = 1'b1;

        // ADD with wrap: exact 4-edge latency, carry and zero set.
        send(3'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        for (int k = 0; k <= S; k++) begin
            @(negedge clk);
            check("add_latency", rsp_valid, (k == S) ? 32'd1 : 32'd0);
        end
        check("add_result", rsp_result, 32'h0000_0000);
        check("add_flags", rsp_flags, 32'b011);
        retire();

        // SUB signed overflow.
        send(3'd1, 32'h8000_0000, 32'h0000_0001);
        wait_rsp();
        check("sub_result", rsp_result, 32'h7FFF_FFFF);
        check("sub_flags", rsp_flags, 32'b110);
        retire();

        // SLT: junk carry/overflow from the ALU must be masked.
        send(3'd2, 32'd5, 32'd7);
        wait_rsp();
        check("slt_result", rsp_result, 32'h0000_0001);
        check("slt_flags", rsp_flags, 32'b000);
        retire();

        // Backpressure with a competing request and wandering operands.
        send(3'd0, 32'h1234_5678, 32'h1111_1111);
        for (int k = 0; k < S + 10; k++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b1;
            req_cmd = 3'd7;
            req_a = $urandom;
            req_b = $urandom;
            @(negedge clk);
            check("bp_req_ready", req_ready, 32'd0);
            check("bp_operandA", alu_operandA, 32'h1234_5678);
        end
        check("bp_rsp_valid", rsp_valid, 32'd1);
        check("bp_result", rsp_result, 32'h2345_6789);
        check("bp_flags", rsp_flags, 32'b000);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        retire();
        @(negedge clk);
        check("bp_idle", busy, 32'd0);

        // Reset during the settle window.
        send(3'd1, 32'h0000_0009, 32'h0000_0003);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("amid_busy", busy, 32'd0);
        check("amid_req_ready", req_ready, 32'd1);
        check("amid_operandA", alu_operandA, 32'd0);
        check("amid_operandB", alu_operandB, 32'd0);
        check("amid_command", alu_command, 32'd0);
        check("amid_result", rsp_result, 32'd0);
        check("amid_flags", rsp_flags, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_rst_no_rsp", rsp_valid, 32'd0);
        end
        send(3'd3, 32'hAAAA_5555, 32'hFFFF_0000);
        wait_rsp();
        check("xor_result", rsp_result, 32'h5555_5555);
        check("xor_flags", rsp_flags, 32'b000);
        retire();

        // Streaming with the consumer always ready.
        hs_times.delete();
        rsp_ready = 1'b1;
        send(3'd0, 32'd1, 32'd2);
        send(3'd1, 32'd10, 32'd3);
        send(3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00);
        for (int n = 0; n < 100 && hs_times.size() < 3; n++) @(negedge clk);
        for (int n = 0; n < 10; n++) @(negedge clk);
        check("stream_count", hs_times.size(), 32'd3);
        if (hs_times.size() >= 3) begin
            check("stream_gap1", hs_times[1] - hs_times[0], SPACING);
            check("stream_gap2", hs_times[2] - hs_times[1], SPACING);
        end
        check("stream_last_result", rsp_result, 32'hF000_F000);
        rsp_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
